// File: rtl/cla_seq_add_ctrl_pkg.sv
// Shared types and sizing helpers for the sequential carry-lookahead add/subtract block.
// Operand widths are fixed per instance; the helpers derive slice count and counter width.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_DATA_WIDTH  = 64;
   localparam int unsigned DEF_SLICE_WIDTH = 16;
   localparam int unsigned NUM_SLICES      = DEF_DATA_WIDTH / DEF_SLICE_WIDTH;
   localparam int unsigned CNT_W           = $clog2(NUM_SLICES);

   function automatic int unsigned num_slices(input int unsigned dw, input int unsigned sw);
      return dw / sw;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // The slice is built from 2-bit cells and the sequencer needs at least two passes.
   function automatic bit cfg_ok(input int unsigned dw, input int unsigned sw);
      return (sw != 0) && (sw % 2 == 0) && (dw % sw == 0) && (dw / sw >= 2);
   endfunction

endpackage

// File: rtl/cla_seq_add_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_add_ctrl.
// slave = the adder block, master = the requester/consumer.
interface cla_seq_add_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 64
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] a_in;
   logic [DATA_WIDTH-1:0] b_in;
   logic                  c_in;
   logic                  sub_en;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] sum;
   logic                  c_out;
   logic                  busy;

   modport slave (
      input  in_valid, a_in, b_in, c_in, sub_en, out_ready,
      output in_ready, out_valid, sum, c_out, busy
   );

   modport master (
      output in_valid, a_in, b_in, c_in, sub_en, out_ready,
      input  in_ready, out_valid, sum, c_out, busy
   );
endinterface

// File: rtl/cla_seq_add_ctrl_slice.sv
// Combinational SLICE_WIDTH adder: 2-bit lookahead cells chained by ripple carry.
module cla_slice #(
   parameter int unsigned SLICE_WIDTH = 16
) (
   input  logic [SLICE_WIDTH-1:0] a,
   input  logic [SLICE_WIDTH-1:0] b,
   input  logic                   cin,
   output logic [SLICE_WIDTH-1:0] s,
   output logic                   cout
);
   localparam int unsigned NCELL = SLICE_WIDTH / 2;

   logic [NCELL:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NCELL; i++) begin : g_cell
      logic g0, p0, g1, p1;
      assign g0 = a[2*i]   & b[2*i];
      assign p0 = a[2*i]   ^ b[2*i];
      assign g1 = a[2*i+1] & b[2*i+1];
      assign p1 = a[2*i+1] ^ b[2*i+1];
      // Both cell carries come straight from generate/propagate and the cell carry-in.
      assign s[2*i]   = p0 ^ c[i];
      assign s[2*i+1] = p1 ^ (g0 | (p0 & c[i]));
      assign c[i+1]   = g1 | (p1 & g0) | (p1 & p0 & c[i]);
   end

   assign cout = c[NCELL];
endmodule

// File: rtl/cla_seq_add_ctrl.sv
// Sequential wide add/subtract: one CLA slice reused over NUM_SLICES cycles,
// with the inter-slice carry held in a register between passes.
module cla_seq_add_ctrl
   import cla_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned SLICE_WIDTH = DEF_SLICE_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   cla_seq_add_ctrl_if.slave bus
);
   localparam int unsigned SLICES = num_slices(DATA_WIDTH, SLICE_WIDTH);
   localparam int unsigned CW     = cnt_width(SLICES);

   if (!cfg_ok(DATA_WIDTH, SLICE_WIDTH)) begin : g_bad_cfg
      $error("cla_seq_add_ctrl: DATA_WIDTH must be a multiple of an even SLICE_WIDTH with at least 2 slices");
   end

   state_t state_q, state_d;

   logic [SLICES-1:0][SLICE_WIDTH-1:0] a_q;
   logic [SLICES-1:0][SLICE_WIDTH-1:0] b_q;
   logic [SLICES-1:0][SLICE_WIDTH-1:0] sum_q;
   logic [CW-1:0]                      cnt_q;
   logic                               carry_q;
   logic                               c_out_q;

   logic [SLICE_WIDTH-1:0] slice_s;
   logic                   slice_cy;
   logic                   last_slice;
   logic                   accept;

   cla_slice #(
      .SLICE_WIDTH(SLICE_WIDTH)
   ) u_slice (
      .a    (a_q[cnt_q]),
      .b    (b_q[cnt_q]),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cy)
   );

   assign last_slice = (cnt_q == CW'(SLICES - 1));
   assign accept     = (state_q == IDLE) && bus.in_valid;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid) state_d = RUN;
         RUN:     if (last_slice)   state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Subtraction is folded in at capture time: B is stored inverted and the carry seeded with 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
      end else if (accept) begin
         a_q     <= bus.a_in;
         b_q     <= bus.sub_en ? ~bus.b_in : bus.b_in;
         carry_q <= bus.sub_en ? 1'b1 : bus.c_in;
         cnt_q   <= '0;
      end else if (state_q == RUN) begin
         sum_q[cnt_q] <= slice_s;
         carry_q      <= slice_cy;
         cnt_q        <= cnt_q + CW'(1);
         if (last_slice) c_out_q <= slice_cy;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum       = sum_q;
   assign bus.c_out     = c_out_q;
endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Self-checking bench for cla_seq_add_ctrl at 64-bit operands, 16-bit slices.
module tb_cla_seq_add_ctrl;
   localparam int unsigned DW = 64;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   cla_seq_add_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   cla_seq_add_ctrl #(
      .DATA_WIDTH  (DW),
      .SLICE_WIDTH (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain wide arithmetic; for subtract, carry out means a >= b (no borrow).
   function automatic logic [DW:0] ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic cin, input logic sub);
      logic [DW:0] r;
      if (sub) r = {(a >= b), a - b};
      else     r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
      return r;
   endfunction

   function automatic logic [DW-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // Issues one operation; lat = edges from acceptance to out_valid, -1 on timeout.
   task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cin,
                         input logic sub, input bit release_out,
                         output logic [DW-1:0] s, output logic c, output int lat);
      int n;
      bus.a_in = a; bus.b_in = b; bus.c_in = cin; bus.sub_en = sub;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 20) begin tick(); n++; end
      lat = -1; s = '0; c = 1'b0;
      if (!bus.in_ready) begin
         bus.in_valid = 1'b0;
         return;
      end
      tick();
      bus.in_valid = 1'b0;
      bus.a_in = rnd64(); bus.b_in = rnd64();
      bus.c_in = 1'($urandom()); bus.sub_en = 1'($urandom());
      n = 0;
      do begin tick(); n++; end while (!bus.out_valid && n < 20);
      if (bus.out_valid) lat = n;
      s = bus.sum; c = bus.c_out;
      if (release_out) begin
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
      checks++; if (bus.c_out !== 1'b0) begin errors++; $display("FAIL reset_c_out got=%b exp=0", bus.c_out); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      logic [DW-1:0] a[4], b[4];
      logic          ci[4], sb[4];
      logic [DW-1:0] s;
      logic          c;
      logic [DW:0]   e;
      int            lat;
      a[0] = 64'hFFFF_FFFF_FFFF_FFFF; b[0] = 64'd1; ci[0] = 1'b0; sb[0] = 1'b0;
      a[1] = 64'd5;                   b[1] = 64'd7; ci[1] = 1'b0; sb[1] = 1'b1;
      a[2] = 64'd7;                   b[2] = 64'd5; ci[2] = 1'b0; sb[2] = 1'b1;
      a[3] = 64'h0000_0000_FFFF_FFFF; b[3] = 64'd0; ci[3] = 1'b1; sb[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         run_op(a[i], b[i], ci[i], sb[i], 1'b1, s, c, lat);
         e = ref_op(a[i], b[i], ci[i], sb[i]);
         checks++; if (lat != 4) begin errors++; $display("FAIL directed%0d_latency got=%0d exp=4", i, lat); end
         checks++; if (s !== e[DW-1:0]) begin errors++; $display("FAIL directed%0d_sum got=%h exp=%h", i, s, e[DW-1:0]); end
         checks++; if (c !== e[DW]) begin errors++; $display("FAIL directed%0d_c_out got=%b exp=%b", i, c, e[DW]); end
         checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL directed%0d_release got out_valid=%b in_ready=%b exp 0/1", i, bus.out_valid, bus.in_ready);
         end
      end
      // Spot-check the fixed answers so the model itself is anchored.
      e = ref_op(64'd5, 64'd7, 1'b0, 1'b1);
      checks++; if (e !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}) begin errors++; $display("FAIL model_sub got=%h", e); end
   endtask

   task automatic test_random();
      logic [DW-1:0] a, b, s;
      logic          ci, sb, c;
      logic [DW:0]   e;
      int            lat;
      for (int i = 0; i < 24; i++) begin
         a = rnd64(); b = rnd64();
         if (i % 6 == 0) b = ~a;
         ci = 1'($urandom()); sb = 1'($urandom());
         run_op(a, b, ci, sb, 1'b1, s, c, lat);
         e = ref_op(a, b, ci, sb);
         checks++; if (lat != 4 || s !== e[DW-1:0] || c !== e[DW]) begin
            errors++;
            $display("FAIL random%0d a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h c=%b exp lat=4 sum=%h c=%b",
                     i, a, b, ci, sb, lat, s, c, e[DW-1:0], e[DW]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] a, b, s;
      logic          c;
      logic [DW:0]   e;
      int            lat;
      bit            held;
      a = rnd64(); b = rnd64();
      run_op(a, b, 1'b1, 1'b0, 1'b0, s, c, lat);
      e = ref_op(a, b, 1'b1, 1'b0);
      checks++; if (lat != 4 || s !== e[DW-1:0] || c !== e[DW]) begin
         errors++; $display("FAIL bp_result got lat=%0d sum=%h c=%b exp 4 %h %b", lat, s, c, e[DW-1:0], e[DW]);
      end
      held = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.out_valid !== 1'b1 || bus.sum !== s || bus.c_out !== c || bus.in_ready !== 1'b0 || bus.busy !== 1'b1)
            held = 1'b0;
      end
      checks++; if (!held) begin
         errors++; $display("FAIL bp_hold got out_valid=%b sum=%h c=%b in_ready=%b busy=%b exp 1 %h %b 0 1",
                            bus.out_valid, bus.sum, bus.c_out, bus.in_ready, bus.busy, s, c);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b busy=%b exp 0 1 0", bus.out_valid, bus.in_ready, bus.busy);
      end
   endtask

   task automatic test_reset_mid_run();
      bit never;
      bus.a_in = rnd64(); bus.b_in = rnd64(); bus.c_in = 1'b0; bus.sub_en = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== '0) begin
         errors++; $display("FAIL midrun_reset got in_ready=%b out_valid=%b busy=%b sum=%h exp 1 0 0 0",
                            bus.in_ready, bus.out_valid, bus.busy, bus.sum);
      end
      never = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) never = 1'b0;
      end
      checks++; if (!never) begin errors++; $display("FAIL midrun_no_valid got out_valid=%b busy=%b exp 0 0", bus.out_valid, bus.busy); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] a1, b1, a2, b2, s1, s2;
      logic          c1, c2;
      logic [DW:0]   e1, e2;
      int            gap, first_valid, n;
      a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = rnd64();
      gap = -1; first_valid = -1; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
      bus.out_ready = 1'b1;
      bus.a_in = a1; bus.b_in = b1; bus.c_in = 1'b1; bus.sub_en = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.a_in = a2; bus.b_in = b2; bus.c_in = 1'b0; bus.sub_en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (bus.out_valid && first_valid < 0) begin
            first_valid = k; s1 = bus.sum; c1 = bus.c_out;
         end
         if (bus.in_ready) begin
            gap = k + 1;
            break;
         end
      end
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!bus.out_valid && n < 20);
      if (bus.out_valid) begin s2 = bus.sum; c2 = bus.c_out; end
      tick();
      bus.out_ready = 1'b0;
      e1 = ref_op(a1, b1, 1'b1, 1'b0);
      e2 = ref_op(a2, b2, 1'b0, 1'b1);
      checks++; if (first_valid != 4) begin errors++; $display("FAIL b2b_first_valid got=%0d exp=4", first_valid); end
      checks++; if (gap != 6) begin errors++; $display("FAIL b2b_gap got=%0d exp=6", gap); end
      checks++; if (s1 !== e1[DW-1:0] || c1 !== e1[DW]) begin
         errors++; $display("FAIL b2b_first got sum=%h c=%b exp sum=%h c=%b", s1, c1, e1[DW-1:0], e1[DW]);
      end
      checks++; if (n != 4 || s2 !== e2[DW-1:0] || c2 !== e2[DW]) begin
         errors++; $display("FAIL b2b_second got lat=%0d sum=%h c=%b exp 4 %h %b", n, s2, c2, e2[DW-1:0], e2[DW]);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a_in = '0; bus.b_in = '0; bus.c_in = 1'b0; bus.sub_en = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
